// File: rtl/keypad_emulator_if.sv
// Handshake and scan lines between a keypad scanner/command source (master) and the keypad emulator (slave).
interface keypad_emulator_if;
   logic [3:0] key_row;
   logic [2:0] key_col;
   logic       cmd_valid;
   logic [3:0] cmd_key;
   logic       cmd_ready;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output key_row, cmd_valid, cmd_key,
      input  key_col, cmd_ready, busy, done, err
   );

   modport slave (
      input  key_row, cmd_valid, cmd_key,
      output key_col, cmd_ready, busy, done, err
   );
endinterface

// File: rtl/keypad_emulator.sv
// 4x3 keypad emulator: holds a key for HOLD_SCANS target-row strobes, releases for GAP_SCANS; key_col is combinational.
// done/err pulse one cycle after the deciding edge; cmd_ready backpressures (4-deep queue with KEYPAD_EMU_QUEUE_EN).
module keypad_emulator #(
   parameter int HOLD_SCANS = 4,
   parameter int GAP_SCANS  = 2
) (
   input logic              clk,
   input logic              rst,
   keypad_emulator_if.slave kp
);
   typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_SCANS - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_SCANS - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hit_cnt;
   logic [3:0] tgt_row;
   logic [2:0] tgt_col;
   logic       done_q;
   logic       err_q;
   logic       hit;
   logic       accept;
   logic       cmd_ok;
   logic       gap_end;
   logic       slot_free;
   logic       start_vld;
   logic       take;
   logic       ready_raw;
   logic [3:0] start_key;
   logic [6:0] start_map;

   // {row one-hot, col one-hot}; invalid codes map to all zeros
   function automatic logic [6:0] key_map(input logic [3:0] k);
      case (k)
         4'd1:    key_map = {4'b1000, 3'b100};
         4'd2:    key_map = {4'b1000, 3'b010};
         4'd3:    key_map = {4'b1000, 3'b001};
         4'd4:    key_map = {4'b0100, 3'b100};
         4'd5:    key_map = {4'b0100, 3'b010};
         4'd6:    key_map = {4'b0100, 3'b001};
         4'd7:    key_map = {4'b0010, 3'b100};
         4'd8:    key_map = {4'b0010, 3'b010};
         4'd9:    key_map = {4'b0010, 3'b001};
         4'd10:   key_map = {4'b0001, 3'b100};
         4'd0:    key_map = {4'b0001, 3'b010};
         4'd11:   key_map = {4'b0001, 3'b001};
         default: key_map = 7'b0;
      endcase
   endfunction

   assign hit       = (kp.key_row == tgt_row);
   assign cmd_ok    = (kp.cmd_key < 4'd12);
   assign accept    = kp.cmd_valid && kp.cmd_ready;
   assign gap_end   = (state == GAP) && hit && (hit_cnt == GAP_LAST);
   assign slot_free = (state == IDLE) || gap_end;
   assign take      = slot_free && start_vld;
   assign start_map = key_map(start_key);

`ifdef KEYPAD_EMU_QUEUE_EN
   logic [3:0] fifo_mem [4];
   logic [1:0] rd_ptr;
   logic [1:0] wr_ptr;
   logic [2:0] fifo_cnt;
   logic       fifo_empty;
   logic       push;
   logic       pop;

   // An empty queue lets an incoming command bypass straight into PRESS
   assign fifo_empty = (fifo_cnt == 3'd0);
   assign start_vld  = !fifo_empty || (accept && cmd_ok);
   assign start_key  = fifo_empty ? kp.cmd_key : fifo_mem[rd_ptr];
   assign pop        = take && !fifo_empty;
   assign push       = accept && cmd_ok && !(take && fifo_empty);
   assign ready_raw  = (fifo_cnt != 3'd4);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= kp.cmd_key;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= 2'd0;
         wr_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         if (push && !pop)      fifo_cnt <= fifo_cnt + 3'd1;
         else if (pop && !push) fifo_cnt <= fifo_cnt - 3'd1;
      end
   end
`else
   assign start_vld = accept && cmd_ok;
   assign start_key = kp.cmd_key;
   assign ready_raw = (state == IDLE);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = PRESS;
         PRESS:   if (hit && (hit_cnt == HOLD_LAST)) state_nxt = GAP;
         GAP:     if (gap_end) state_nxt = take ? PRESS : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt <= 8'd0;
         tgt_row <= 4'd0;
         tgt_col <= 3'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (state_nxt != state)
            hit_cnt <= 8'd0;
         else if (hit && (state != IDLE))
            hit_cnt <= hit_cnt + 8'd1;
         if (take) {tgt_row, tgt_col} <= start_map;
         done_q <= gap_end;
         err_q  <= accept && !cmd_ok;
      end
   end

   always_comb begin
      kp.key_col = 3'b000;
      if ((state == PRESS) && hit) kp.key_col = tgt_col;
      kp.busy      = (state != IDLE);
      kp.cmd_ready = ready_raw && !rst;
      kp.done      = done_q;
      kp.err       = err_q;
   end
endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: key-map table, directed corner sequences and randomized traffic vs a press-count model.
module tb_keypad_emulator;
   localparam int HOLD = 4;
   localparam int GAP  = 2;

   typedef struct {
      logic [3:0] key;
      logic [3:0] row;
      logic [2:0] col;
      logic       bad;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   keypad_emulator_if bus();

   keypad_emulator #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP)) dut (
      .clk(clk),
      .rst(rst),
      .kp (bus)
   );

   vec_t vt [16];
   int   keymap [4][3];
   int   checks = 0;
   int   errors = 0;

   // reference model: strobes still owed for the current press and release
   int         m_press;
   int         m_gap;
   logic [3:0] m_key;
   logic [3:0] m_q [$];
   logic       m_done;
   logic       m_err;

   int obs_strobes, obs_done, obs_err, obs_busy, obs_wrong;
   int obs_seq [$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int row_idx(input logic [3:0] r);
      case (r)
         4'b1000: return 0;
         4'b0100: return 1;
         4'b0010: return 2;
         4'b0001: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic int col_idx(input logic [2:0] c);
      case (c)
         3'b100:  return 0;
         3'b010:  return 1;
         3'b001:  return 2;
         default: return -1;
      endcase
   endfunction

   function automatic logic [3:0] rot(input int i);
      logic [3:0] base;
      base = 4'b1000;
      return base >> (i % 4);
   endfunction

   function automatic logic exp_ready();
`ifdef KEYPAD_EMU_QUEUE_EN
      return !rst && (m_q.size() < 4);
`else
      return !rst && (m_press == 0) && (m_gap == 0);
`endif
   endfunction

   task automatic model_update();
      logic hit, acc, fin, can_start;
      if (rst) begin
         m_press = 0;
         m_gap   = 0;
         m_q.delete();
         m_done  = 1'b0;
         m_err   = 1'b0;
         return;
      end
      hit       = (bus.key_row == vt[m_key].row);
      acc       = bus.cmd_valid && exp_ready();
      fin       = (m_press == 0) && (m_gap == 1) && hit;
      can_start = ((m_press == 0) && (m_gap == 0)) || fin;
      m_err     = acc && vt[bus.cmd_key].bad;
      m_done    = fin;
      if (m_press > 0) begin
         if (hit) m_press--;
      end else if (m_gap > 0) begin
         if (hit) m_gap--;
      end
      if (acc && !vt[bus.cmd_key].bad) m_q.push_back(bus.cmd_key);
      if (can_start && (m_q.size() > 0)) begin
         m_key   = m_q.pop_front();
         m_press = HOLD;
         m_gap   = GAP;
      end
   endtask

   task automatic obs_clear();
      obs_strobes = 0; obs_done = 0; obs_err = 0; obs_busy = 0; obs_wrong = 0;
      obs_seq.delete();
   endtask

   // inputs are already applied; check at negedge, advance model at posedge
   task automatic cycle();
      logic       hit, busy_m;
      logic [2:0] ecol;
      int         r, c, d;
      @(negedge clk);
      hit    = (bus.key_row == vt[m_key].row);
      busy_m = (m_press > 0) || (m_gap > 0);
      ecol   = ((m_press > 0) && hit) ? vt[m_key].col : 3'b000;
      chk("key_col",   8'(bus.key_col),   8'(ecol));
      chk("busy",      8'(bus.busy),      8'(busy_m));
      chk("cmd_ready", 8'(bus.cmd_ready), 8'(exp_ready()));
      chk("done",      8'(bus.done),      8'(m_done));
      chk("err",       8'(bus.err),       8'(m_err));
      if (bus.done === 1'b1) obs_done++;
      if (bus.err  === 1'b1) obs_err++;
      if (bus.busy === 1'b1) obs_busy++;
      if (bus.key_col !== 3'b000) begin
         obs_strobes++;
         r = row_idx(bus.key_row);
         c = col_idx(bus.key_col);
         if ((r < 0) || (c < 0)) obs_wrong++;
         else begin
            d = keymap[r][c];
            if ((obs_seq.size() == 0) || (obs_seq[$] != d)) obs_seq.push_back(d);
         end
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic run_key(input logic [3:0] k, input int budget);
      obs_clear();
      bus.cmd_valid = 1'b1;
      bus.cmd_key   = k;
      bus.key_row   = 4'b0000;
      cycle();
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < budget; i++) begin
         bus.key_row = rot(i);
         cycle();
      end
   endtask

   initial begin
      vt[0]  = '{4'd0,  4'b0001, 3'b010, 1'b0};
      vt[1]  = '{4'd1,  4'b1000, 3'b100, 1'b0};
      vt[2]  = '{4'd2,  4'b1000, 3'b010, 1'b0};
      vt[3]  = '{4'd3,  4'b1000, 3'b001, 1'b0};
      vt[4]  = '{4'd4,  4'b0100, 3'b100, 1'b0};
      vt[5]  = '{4'd5,  4'b0100, 3'b010, 1'b0};
      vt[6]  = '{4'd6,  4'b0100, 3'b001, 1'b0};
      vt[7]  = '{4'd7,  4'b0010, 3'b100, 1'b0};
      vt[8]  = '{4'd8,  4'b0010, 3'b010, 1'b0};
      vt[9]  = '{4'd9,  4'b0010, 3'b001, 1'b0};
      vt[10] = '{4'd10, 4'b0001, 3'b100, 1'b0};
      vt[11] = '{4'd11, 4'b0001, 3'b001, 1'b0};
      vt[12] = '{4'd12, 4'b0000, 3'b000, 1'b1};
      vt[13] = '{4'd13, 4'b0000, 3'b000, 1'b1};
      vt[14] = '{4'd14, 4'b0000, 3'b000, 1'b1};
      vt[15] = '{4'd15, 4'b0000, 3'b000, 1'b1};
      keymap = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

      m_press = 0; m_gap = 0; m_key = 4'd1; m_done = 1'b0; m_err = 1'b0;
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_key   = 4'd0;
      bus.key_row   = 4'b0000;
      @(posedge clk); #1;
      @(posedge clk); #1;

      chk("rst_cmd_ready", 8'(bus.cmd_ready), 8'd0);
      chk("rst_key_col",   8'(bus.key_col),   8'd0);
      chk("rst_busy",      8'(bus.busy),      8'd0);
      chk("rst_done",      8'(bus.done),      8'd0);
      chk("rst_err",       8'(bus.err),       8'd0);
      cycle();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 8'(bus.cmd_ready), 8'd1);

      // key map table: every code pressed under a rotating scanner
      for (int i = 0; i < 16; i++) begin
         run_key(vt[i].key, 4 * (HOLD + GAP) + 8);
         chk($sformatf("strobes_k%0d", i), 8'(obs_strobes), vt[i].bad ? 8'd0 : 8'(HOLD));
         chk($sformatf("dones_k%0d", i),   8'(obs_done),    vt[i].bad ? 8'd0 : 8'd1);
         chk($sformatf("errs_k%0d", i),    8'(obs_err),     vt[i].bad ? 8'd1 : 8'd0);
         chk($sformatf("wrong_k%0d", i),   8'(obs_wrong),   8'd0);
         chk($sformatf("nseq_k%0d", i),    8'(obs_seq.size()), vt[i].bad ? 8'd0 : 8'd1);
         if (vt[i].bad) chk($sformatf("busy_k%0d", i), 8'(obs_busy), 8'd0);
         else if (obs_seq.size() == 1) chk($sformatf("decode_k%0d", i), 8'(obs_seq[0]), 8'(vt[i].key));
      end

      // stalled scanner: idle rows and multi-hot rows never count
      obs_clear();
      bus.cmd_valid = 1'b1; bus.cmd_key = 4'd5; bus.key_row = 4'b0000;
      cycle();
      bus.cmd_valid = 1'b0;
      repeat (10) cycle();
      bus.key_row = 4'b1100;
      repeat (10) cycle();
      chk("stall_strobes", 8'(obs_strobes), 8'd0);
      chk("stall_busy",    8'(obs_busy),    8'd20);
      bus.key_row = 4'b0100;
      repeat (HOLD + GAP) cycle();
      chk("stall_hold", 8'(obs_strobes), 8'(HOLD));
      bus.key_row = 4'b0000;
      cycle(); cycle();
      chk("stall_done", 8'(obs_done), 8'd1);

      // reset on the second hit of key 9
      obs_clear();
      bus.cmd_valid = 1'b1; bus.cmd_key = 4'd9; bus.key_row = 4'b0000;
      cycle();
      bus.cmd_valid = 1'b0;
      bus.key_row = 4'b0010; cycle();
      bus.key_row = 4'b0000; cycle();
      bus.key_row = 4'b0010; rst = 1'b1; cycle();
      rst = 1'b0;
      #1;
      chk("rst_mid_col",  8'(bus.key_col), 8'd0);
      chk("rst_mid_busy", 8'(bus.busy),    8'd0);
      chk("rst_mid_hits", 8'(obs_strobes), 8'd2);
      cycle();
      run_key(4'd3, 4 * (HOLD + GAP) + 8);
      chk("after_rst_strobes", 8'(obs_strobes), 8'(HOLD));
      chk("after_rst_done",    8'(obs_done),    8'd1);
      chk("after_rst_nseq",    8'(obs_seq.size()), 8'd1);
      if (obs_seq.size() == 1) chk("after_rst_key", 8'(obs_seq[0]), 8'd3);

`ifdef KEYPAD_EMU_QUEUE_EN
      // five back-to-back commands fill the queue, then run in order
      obs_clear();
      bus.key_row = 4'b0000;
      for (int i = 1; i <= 5; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_key   = 4'(i);
         cycle();
      end
      bus.cmd_valid = 1'b0;
      #1;
      chk("q_full_ready", 8'(bus.cmd_ready), 8'd0);
      for (int i = 0; i < 5 * 4 * (HOLD + GAP) + 10; i++) begin
         bus.key_row = rot(i);
         cycle();
      end
      chk("q_dones", 8'(obs_done), 8'd5);
      chk("q_nseq",  8'(obs_seq.size()), 8'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("q_order%0d", i), (i < obs_seq.size()) ? 8'(obs_seq[i]) : 8'hff, 8'(i + 1));
`endif

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         rst           = ($urandom_range(0, 199) == 0);
         bus.cmd_valid = ($urandom_range(0, 4) == 0);
         bus.cmd_key   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) bus.key_row = 4'($urandom_range(0, 15));
         else                          bus.key_row = rot(int'($urandom_range(0, 3)));
         cycle();
      end
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
